// File: rtl/nabp_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : nabp_fir_filter
//  Purpose  : Streaming FIR ramp filter on the projection path ahead of back
//             projection. Provides loadable coefficients, per-line zeroing of
//             the sample history, a bypass mode with the same group delay,
//             a valid/ready input handshake and output saturation.
//  Ports    : clk, reset (async, active-high)
//             enable, bypass, in_valid, in_ready, line_start, val_in
//               - sample input side; accept on in_valid & in_ready
//             out_valid, val_out
//               - filtered output, fixed 3-edge latency, no backpressure
//             coef_load, coef_wr_en, coef_wr_data, coef_busy
//               - coefficient reload handshake
//             sat_flag - sticky, set by any output clamp
//  Revision : 1.0 - initial release
// ============================================================================
module nabp_fir_filter #(
    parameter int pDataLength         = 12,
    parameter int pFilteredDataLength = 16,
    parameter int pCoefLength         = 12,
    parameter int pCoefFrac           = 11,
    parameter int pNumTaps            = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  bypass,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  line_start,
    input  logic signed [pDataLength-1:0]         val_in,
    output logic                                  out_valid,
    output logic signed [pFilteredDataLength-1:0] val_out,
    input  logic                                  coef_load,
    input  logic                                  coef_wr_en,
    input  logic signed [pCoefLength-1:0]         coef_wr_data,
    output logic                                  coef_busy,
    output logic                                  sat_flag
);

    localparam int c_centre = (pNumTaps - 1) / 2;
    // Coefficient storage is widened when needed so that the +1.0 identity
    // tap (1<<pCoefFrac) is exactly representable as a positive value.
    localparam int c_coef_w = (pCoefLength < pCoefFrac + 2) ? (pCoefFrac + 2) : pCoefLength;
    localparam int c_prod_w = pDataLength + c_coef_w;
    localparam int c_acc_w  = c_prod_w + $clog2(pNumTaps);
    localparam int c_ptr_w  = $clog2(pNumTaps);

    localparam logic [c_ptr_w-1:0]         c_last_ptr = c_ptr_w'(pNumTaps - 1);
    localparam logic signed [c_coef_w-1:0] c_coef_one = {{(c_coef_w-1){1'b0}}, 1'b1} << pCoefFrac;
    localparam logic signed [c_acc_w-1:0]  c_round    = {{(c_acc_w-1){1'b0}}, 1'b1} << (pCoefFrac - 1);
    localparam logic signed [c_acc_w-1:0]  c_out_max  =
        {{(c_acc_w-pFilteredDataLength+1){1'b0}}, {(pFilteredDataLength-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0]  c_out_min  = ~c_out_max;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                              r_state;
    logic [c_ptr_w-1:0]                  r_ptr;
    logic signed [c_coef_w-1:0]          r_coef  [pNumTaps];
    logic signed [pDataLength-1:0]       r_dly   [pNumTaps];

    logic                                r_v0;
    logic                                r_byp0;
    logic signed [c_prod_w-1:0]          r_prod  [pNumTaps];
    logic                                r_v1;
    logic                                r_byp1;
    logic signed [pDataLength-1:0]       r_bypd1;
    logic                                r_v2;
    logic signed [pFilteredDataLength-1:0] r_res2;

    logic                                w_accept;
    logic                                w_load_last;
    logic signed [c_acc_w-1:0]           w_sum;
    logic signed [c_acc_w-1:0]           w_rnd;
    logic                                w_clamp_hi;
    logic                                w_clamp_lo;
    logic signed [pFilteredDataLength-1:0] w_res;

    assign in_ready    = enable & (r_state == ST_RUN);
    assign w_accept    = in_valid & in_ready;
    assign w_load_last = (r_state == ST_LOAD) & coef_wr_en & (r_ptr == c_last_ptr);

    // ------------------------------------------------------------------
    // Control FSM and coefficient bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_ptr     <= '0;
            coef_busy <= 1'b0;
            for (int i = 0; i < pNumTaps; i++) begin
                r_coef[i] <= (i == c_centre) ? c_coef_one : '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (coef_load) begin
                        r_state   <= ST_DRAIN;
                        coef_busy <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Coefficients are only consumed in stage 1; once no
                    // sample is left in any stage it is safe to overwrite.
                    if (!(r_v0 | r_v1 | r_v2)) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (coef_wr_en) begin
                        r_coef[r_ptr] <= c_coef_w'(coef_wr_data);
                        r_ptr         <= r_ptr + 1'b1;
                        if (r_ptr == c_last_ptr) begin
                            r_state   <= ST_RUN;
                            coef_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    coef_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // E0: delay line shift on accept; history cleared on line_start and
    // when a coefficient load completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < pNumTaps; i++) begin
                r_dly[i] <= '0;
            end
        end else if (w_load_last) begin
            for (int i = 0; i < pNumTaps; i++) begin
                r_dly[i] <= '0;
            end
        end else if (w_accept) begin
            r_dly[0] <= val_in;
            for (int i = 1; i < pNumTaps; i++) begin
                r_dly[i] <= line_start ? '0 : r_dly[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0   <= 1'b0;
            r_byp0 <= 1'b0;
        end else begin
            r_v0 <= w_accept;
            if (w_accept) begin
                r_byp0 <= bypass;
            end
        end
    end

    // ------------------------------------------------------------------
    // E1: full-precision products, bypass tap captured alongside
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_byp1  <= 1'b0;
            r_bypd1 <= '0;
            for (int i = 0; i < pNumTaps; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_v1    <= r_v0;
            r_byp1  <= r_byp0;
            r_bypd1 <= r_dly[c_centre];
            for (int i = 0; i < pNumTaps; i++) begin
                r_prod[i] <= c_prod_w'(r_dly[i]) * c_prod_w'(r_coef[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum, round half up, saturate
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < pNumTaps; i++) begin
            w_sum = w_sum + c_acc_w'(r_prod[i]);
        end
        w_rnd      = (w_sum + c_round) >>> pCoefFrac;
        w_clamp_hi = (w_rnd > c_out_max);
        w_clamp_lo = (w_rnd < c_out_min);
        if (r_byp1) begin
            w_res = pFilteredDataLength'(r_bypd1);
        end else if (w_clamp_hi) begin
            w_res = c_out_max[pFilteredDataLength-1:0];
        end else if (w_clamp_lo) begin
            w_res = c_out_min[pFilteredDataLength-1:0];
        end else begin
            w_res = w_rnd[pFilteredDataLength-1:0];
        end
    end

    // ------------------------------------------------------------------
    // E2: registered result and sticky saturation flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2     <= 1'b0;
            r_res2   <= '0;
            sat_flag <= 1'b0;
        end else begin
            r_v2     <= r_v1;
            r_res2   <= w_res;
            sat_flag <= sat_flag | (r_v1 & ~r_byp1 & (w_clamp_hi | w_clamp_lo));
        end
    end

    // ------------------------------------------------------------------
    // E3: output register; val_out holds between results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            val_out   <= '0;
        end else begin
            out_valid <= r_v2;
            if (r_v2) begin
                val_out <= r_res2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nabp_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nabp_fir_filter
//  Purpose  : Self-checking bench for nabp_fir_filter. A behavioural model
//             predicts each result when a sample is accepted and queues it
//             with its due cycle; a monitor pops and compares on out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nabp_fir_filter;

    localparam int c_dl   = 12;
    localparam int c_w    = 14;
    localparam int c_cl   = 13;
    localparam int c_frac = 11;
    localparam int c_nt   = 16;
    localparam int c_d    = (c_nt - 1) / 2;
    localparam longint c_max = (longint'(1) <<< (c_w - 1)) - 1;
    localparam longint c_min = -(longint'(1) <<< (c_w - 1));

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic bypass = 1'b0;
    logic in_valid = 1'b0;
    logic line_start = 1'b0;
    logic coef_load = 1'b0;
    logic coef_wr_en = 1'b0;
    logic signed [c_dl-1:0] val_in = '0;
    logic signed [c_cl-1:0] coef_wr_data = '0;
    logic in_ready;
    logic out_valid;
    logic coef_busy;
    logic sat_flag;
    logic signed [c_w-1:0] val_out;

    nabp_fir_filter #(
        .pDataLength         (c_dl),
        .pFilteredDataLength (c_w),
        .pCoefLength         (c_cl),
        .pCoefFrac           (c_frac),
        .pNumTaps            (c_nt)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bypass       (bypass),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .line_start   (line_start),
        .val_in       (val_in),
        .out_valid    (out_valid),
        .val_out      (val_out),
        .coef_load    (coef_load),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_data (coef_wr_data),
        .coef_busy    (coef_busy),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_val = 0;
    int   m_coef [c_nt];
    int   m_d    [c_nt];
    bit   m_sat  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + model: check what the last edge produced, then predict what
    // the coming edge accepts.
    always @(negedge clk) begin : monitor
        exp_t   e;
        longint acc;
        int     y;
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_output: got no out_valid at cycle %0d, expected value %0d at cycle %0d", cyc, e.val, e.cyc);
            end
            n_checks++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got out_valid value %0d at cycle %0d, expected no output", val_out, cyc);
                    last_val = int'(val_out);
                end else begin
                    e = q.pop_front();
                    if (int'(val_out) !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL output: got %0d at cycle %0d, expected %0d at cycle %0d", val_out, cyc, e.val, e.cyc);
                    end
                    last_val = e.val;
                end
            end else if (int'(val_out) !== last_val) begin
                n_fail++;
                $display("FAIL hold: got val_out %0d with out_valid low, expected %0d", val_out, last_val);
            end

            if (in_valid && in_ready) begin
                if (line_start) begin
                    for (int i = 1; i < c_nt; i++) m_d[i] = 0;
                end else begin
                    for (int i = c_nt - 1; i > 0; i--) m_d[i] = m_d[i-1];
                end
                m_d[0] = int'(val_in);
                if (bypass) begin
                    y = m_d[c_d];
                end else begin
                    acc = 0;
                    for (int i = 0; i < c_nt; i++) acc += longint'(m_coef[i]) * longint'(m_d[i]);
                    acc = (acc + (longint'(1) <<< (c_frac - 1))) >>> c_frac;
                    if (acc > c_max) begin
                        acc   = c_max;
                        m_sat = 1'b1;
                    end else if (acc < c_min) begin
                        acc   = c_min;
                        m_sat = 1'b1;
                    end
                    y = int'(acc);
                end
                q.push_back('{y, cyc + 4});
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < c_nt; i++) begin
            m_coef[i] = (i == c_d) ? (1 << c_frac) : 0;
            m_d[i]    = 0;
        end
        m_sat    = 1'b0;
        last_val = 0;
        q.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL wait_idle: got %0d results still pending, expected 0", q.size());
            q.delete();
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_sat();
        n_checks++;
        if (sat_flag !== m_sat) begin
            n_fail++;
            $display("FAIL sat_flag: got %0b, expected %0b", sat_flag, m_sat);
        end
    endtask

    // Back-to-back stream of one value; first sample optionally starts a line.
    task automatic send_const(input int v, input int n, input bit first_ls);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b1;
            val_in     = c_dl'(v);
            line_start = first_ls && (i == 0);
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic load_coefs(input int c[c_nt], input bit early_write, input bit hold_valid);
        coef_load = 1'b1;
        @(posedge clk); #1;
        coef_load = 1'b0;
        in_valid  = hold_valid;
        val_in    = c_dl'(77);
        @(negedge clk);
        n_checks += 2;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_in_ready: got %0b after coef_load, expected 0", in_ready);
        end
        if (coef_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_busy: got %0b after coef_load, expected 1", coef_busy);
        end
        if (early_write) begin
            coef_wr_en   = 1'b1;
            coef_wr_data = c_cl'(-999);
            @(posedge clk); #1;
            coef_wr_en   = 1'b0;
        end
        wait_idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < c_nt; i++) begin
            coef_wr_en   = 1'b1;
            coef_wr_data = c_cl'(c[i]);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_in_ready: got %0b during write %0d, expected 0", in_ready, i);
            end
            @(posedge clk); #1;
        end
        coef_wr_en = 1'b0;
        for (int i = 0; i < c_nt; i++) begin
            m_coef[i] = c[i];
            m_d[i]    = 0;
        end
        @(negedge clk);
        n_checks += 2;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_done_ready: got %0b after last write, expected 1", in_ready);
        end
        if (coef_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_busy: got %0b after last write, expected 0", coef_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b1;
        bypass     = 1'b0;
        in_valid   = 1'b0;
        line_start = 1'b0;
        coef_load  = 1'b0;
        coef_wr_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (val_out !== '0) begin
            n_fail++;
            $display("FAIL reset_val_out: got %0d, expected 0", val_out);
        end
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %0b, expected 0", out_valid);
        end
        if (sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sat_flag: got %0b, expected 0", sat_flag);
        end
        if (coef_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_coef_busy: got %0b, expected 0", coef_busy);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    // Identity reset coefficients: 7 zeros then 5,-3,7.
    task automatic test_impulse();
        int seq [13] = '{5, -3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            val_in   = c_dl'(seq[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();
        check_sat();
    endtask

    // All taps 1.0 on constant 100: ramp to 1600.
    task automatic test_sum();
        int c [c_nt];
        for (int i = 0; i < c_nt; i++) c[i] = 2048;
        load_coefs(c, 1'b0, 1'b0);
        send_const(100, 22, 1'b0);
        wait_idle();
        check_sat();
    endtask

    task automatic test_line_start();
        send_const(100, 20, 1'b1);
        wait_idle();
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        send_const(100, 12, 1'b1);
        bypass = 1'b0;
        wait_idle();
        check_sat();
    endtask

    task automatic test_saturation();
        int c [c_nt];
        check_sat();
        for (int i = 0; i < c_nt; i++) c[i] = 2047;
        load_coefs(c, 1'b0, 1'b0);
        send_const(2047, 20, 1'b0);
        wait_idle();
        check_sat();
        send_const(-2048, 20, 1'b0);
        wait_idle();
        check_sat();
    endtask

    task automatic test_load_in_flight();
        int c [c_nt];
        int k;
        for (int i = 0; i < c_nt; i++) begin
            k = i - c_d;
            if (k == 0)          c[i] = 2048;
            else if (k % 2 != 0) c[i] = -830 / (k * k);
            else                 c[i] = 0;
        end
        in_valid = 1'b1;
        val_in = c_dl'(10); @(posedge clk); #1;
        val_in = c_dl'(20); @(posedge clk); #1;
        val_in = c_dl'(30); @(posedge clk); #1;
        in_valid = 1'b0;
        load_coefs(c, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            in_valid   = ($urandom_range(3) != 0);
            line_start = ($urandom_range(9) == 0);
            bypass     = ($urandom_range(3) == 0);
            val_in     = c_dl'(int'($urandom_range(4095)) - 2048);
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        line_start = 1'b0;
        bypass     = 1'b0;
        wait_idle();
        check_sat();
    endtask

    task automatic test_enable_and_reset_mid_load();
        enable   = 1'b0;
        in_valid = 1'b1;
        val_in   = c_dl'(123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_in_ready: got %0b with enable low, expected 0", in_ready);
            end
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_out_valid: got %0b with enable low, expected 0", out_valid);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        coef_load = 1'b1;
        @(posedge clk); #1;
        coef_load = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            coef_wr_en   = 1'b1;
            coef_wr_data = c_cl'(1000 + i);
            @(posedge clk); #1;
        end
        coef_wr_en = 1'b0;
        test_reset();
        test_impulse();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_impulse();
        test_sum();
        test_line_start();
        test_bypass();
        test_saturation();
        test_load_in_flight();
        test_enable_and_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
